ram_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO built on one `dualPortRam` instance. It uses the RAM's write port as the push side and the RAM's 1-cycle registered read port as the pop side, with pointer, occupancy and read-collision bypass logic. It is the standard buffering primitive between pipeline stages and bus/peripheral blocks in the CPU and SoC fabric.

---
 rtl/ram_fifo.sv | 157 +++++++++++++++
 tb/tb_ram_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo.sv
// ram_fifo: first-word-fall-through FIFO built on a single dualPortRam.
//
// The RAM's write port is the push side. Its registered read port is the pop side.
// The read address looks one word ahead on a pop, so the new head word is on the
// RAM output in the cycle after any pointer move. When a push writes the same
// address that is being read, the RAM's result is undefined. A one-word bypass
// register supplies the data in that case.
//
// Optional feature macro: RAM_FIFO_LEVEL_EN adds the `level` output (occupancy).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear; takes priority over push and pop
//   wrValid/wrReady/wrData   push handshake and data
//   rdValid/rdReady/rdData   pop handshake and head word (FWFT)
//   level        occupancy 0..DEPTH (only with RAM_FIFO_LEVEL_EN)
//
// Also contains dualPortRam: byte-enabled simple dual-port RAM, 1-cycle registered
// read. Read-during-write to the same address returns undefined data.

module dualPortRam #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [WIDTH-1:0]      writeData,
    input  logic                  writeEnable,
    input  logic [WIDTH/8-1:0]    writeByteEnable,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [WIDTH-1:0]      readData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEnable) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (writeByteEnable[b]) begin
                    mem[writeAddress][b*8 +: 8] <= writeData[b*8 +: 8];
                end
            end
        end
        readData <= mem[readAddress];
    end

endmodule

module ram_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wrValid,
    output logic                  wrReady,
    input  logic [WIDTH-1:0]      wrData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic [WIDTH-1:0]      rdData
`ifdef RAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  bypass_hit_q, bypass_hit_d;
    logic [WIDTH-1:0]      bypass_data_q, bypass_data_d;

    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [WIDTH-1:0]      ram_read_data;

    // Handshakes decode straight from the count register.
    assign wrReady = (count_q != CountFull);
    assign rdValid = (count_q != '0);
    assign push    = wrValid & wrReady;
    assign pop     = rdValid & rdReady;

    // Look ahead on a pop so the next head is on the RAM output after the edge.
    assign read_address = rd_ptr_q + ADDR_WIDTH'(pop);

    dualPortRam #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk             (clk),
        .writeAddress    (wr_ptr_q),
        .writeData       (wrData),
        .writeEnable     (push),
        .writeByteEnable ({(WIDTH / 8){1'b1}}),
        .readAddress     (read_address),
        .readData        (ram_read_data)
    );

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        bypass_hit_d  = 1'b0;
        bypass_data_d = bypass_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            // Same-address write and read this edge: RAM output is unreliable, use wrData.
            if (push && (wr_ptr_q == read_address)) begin
                bypass_hit_d  = 1'b1;
                bypass_data_d = wrData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            bypass_hit_q  <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            bypass_hit_q  <= bypass_hit_d;
            bypass_data_q <= bypass_data_d;
        end
    end

    assign rdData = bypass_hit_q ? bypass_data_q : ram_read_data;

`ifdef RAM_FIFO_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_ram_fifo.sv
module tb_ram_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
`ifdef RAM_FIFO_LEVEL_EN
    logic [4:0]  level;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wrValid (wr_valid),
        .wrReady (wr_ready),
        .wrData  (wr_data),
        .rdValid (rd_valid),
        .rdReady (rd_ready),
        .rdData  (rd_data)
`ifdef RAM_FIFO_LEVEL_EN
        ,
        .level   (level)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_level(input string name, input int exp);
`ifdef RAM_FIFO_LEVEL_EN
        chk(name, 32'(level), 32'(exp));
`endif
    endtask

    // Inputs are driven at posedge+1, outputs sampled at posedge+5.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 32'(i), 1'b0, 1'b0);
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic        fl;
        logic        exp_wr_ready;
        logic        exp_rd_valid;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] q[$];

    initial begin
        // Inputs applied this cycle; expected outputs are those visible before the edge.
        vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22};
        vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        // Reset and idle.
        tick();
        tick();
        rst = 1'b0;
        #4;
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk_level("reset_level", 0);
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl);
            #4;
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr_ready));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
            end
            tick();
        end
        idle();

        // Asynchronous reset mid-cycle clears outputs before any edge.
        push_n(3, 32'h70);
        #2;
        chk("pre_async_rd_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_rst_wr_ready", 32'(wr_ready), 32'd1);
        chk_level("async_rst_level", 0);
        tick();
        rst = 1'b0;
        tick();

        // Fill to DEPTH, 17th push refused, drain in order.
        push_n(15, 32'h0);
        #4;
        chk("fill15_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        push_n(1, 32'hF);
        #4;
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk_level("full_level", 16);
        tick();
        drive(1'b1, 32'hFF, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            rd_ready = 1'b1;
            #4;
            chk($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), rd_data, 32'(i));
            tick();
        end
        idle();
        #4;
        chk("drained_rd_valid", 32'(rd_valid), 32'd0);
        tick();

        // Bypass: push to empty, data visible in the next cycle.
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        idle();
        #4;
        chk("bypass_valid", 32'(rd_valid), 32'd1);
        chk("bypass_data", rd_data, 32'hA5A5A5A5);
        tick();
        rd_ready = 1'b1;
        tick();
        idle();

        // Streaming 1..100 with rdReady held; scoreboard queue.
        begin
            int next_val = 1;
            int pops = 0;
            int mcount = 0;
            q.delete();
            for (int cyc = 0; cyc < 300 && pops < 100; cyc++) begin
                drive(next_val <= 100, 32'(next_val), 1'b1, 1'b0);
                #4;
                chk("stream_wr_ready", 32'(wr_ready), 32'(mcount != DEPTH));
                chk("stream_rd_valid", 32'(rd_valid), 32'(mcount != 0));
`ifdef RAM_FIFO_LEVEL_EN
                chk("stream_level_le1", 32'(level <= 1), 32'd1);
`endif
                if (mcount != 0) begin
                    chk("stream_data", rd_data, q[0]);
                    void'(q.pop_front());
                    pops++;
                    mcount--;
                end
                if (next_val <= 100) begin
                    q.push_back(32'(next_val));
                    next_val++;
                    mcount++;
                end
                tick();
            end
            chk("stream_all_popped", 32'(pops), 32'd100);
        end
        idle();
        tick();

        // Full FIFO: pop with wrValid, push refused that cycle, accepted next.
        push_n(16, 32'd100);
        drive(1'b1, 32'hBEEF, 1'b1, 1'b0);
        #4;
        chk("fullpop_wr_ready", 32'(wr_ready), 32'd0);
        chk("fullpop_head", rd_data, 32'd100);
        tick();
        drive(1'b1, 32'hBEEF, 1'b0, 1'b0);
        #4;
        chk("fullpop_wr_ready_after", 32'(wr_ready), 32'd1);
        chk_level("fullpop_level15", 15);
        tick();
        idle();
        #4;
        chk("retry_wr_ready", 32'(wr_ready), 32'd0);
        chk_level("retry_level16", 16);
        tick();
        for (int i = 0; i < 16; i++) begin
            rd_ready = 1'b1;
            #4;
            chk($sformatf("retry_drain%0d", i), rd_data, (i < 15) ? 32'(101 + i) : 32'hBEEF);
            tick();
        end
        idle();
        #4;
        chk("retry_empty", 32'(rd_valid), 32'd0);
        tick();

        // Flush at level 5 with push and pop asserted: everything discarded.
        push_n(5, 32'h200);
        #4;
        chk_level("preflush_level", 5);
        chk("preflush_rd_valid", 32'(rd_valid), 32'd1);
        tick();
        drive(1'b1, 32'h999, 1'b1, 1'b1);
        tick();
        idle();
        #4;
        chk("flush_rd_valid", 32'(rd_valid), 32'd0);
        chk("flush_wr_ready", 32'(wr_ready), 32'd1);
        chk_level("flush_level", 0);
        tick();
        #4;
        chk("flush_stays_empty", 32'(rd_valid), 32'd0);
        tick();

        // After flush the FIFO restarts cleanly.
        push_n(2, 32'h300);
        rd_ready = 1'b1;
        #4;
        chk("postflush_head0", rd_data, 32'h300);
        tick();
        #4;
        chk("postflush_head1", rd_data, 32'h301);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end

endmodule
